// File: rtl/car_sim_pkg.sv
// Shared definitions for the car-simulator link: command bit positions,
// the stop command, the UART transmit state encoding and the command sanitiser.
package car_sim_pkg;

    localparam int CMD_FWD   = 0;
    localparam int CMD_BWD   = 1;
    localparam int CMD_LEFT  = 2;
    localparam int CMD_RIGHT = 3;

    localparam logic [7:0] CMD_STOP = 8'h00;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Opposing requests cancel each other; a disabled link always commands stop.
    function automatic logic [7:0] sanitise_cmd(
        input logic en,
        input logic fwd,
        input logic bwd,
        input logic left,
        input logic right
    );
        logic [7:0] c;
        c = CMD_STOP;
        if (en) begin
            c[CMD_FWD]   = fwd & ~bwd;
            c[CMD_BWD]   = bwd & ~fwd;
            c[CMD_LEFT]  = left & ~right;
            c[CMD_RIGHT] = right & ~left;
        end else begin
            c = CMD_STOP;
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Byte-in / serial-out UART 8N1 transmitter with start/busy/done handshake.
// All outputs are registered from the next-state values so they move with the state.
module uart_tx_core
    import car_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    tx_state_e     r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    tx_state_e     w_state_nxt;
    logic [CW-1:0] w_clk_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_clk_last;

    assign w_clk_last = (r_clk_cnt == CNT_LAST);

    // Next-state, counter and shift-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            TX_IDLE: begin
                if (i_start) begin
                    w_state_nxt = TX_START;
                    w_clk_nxt   = CNT_ZERO;
                    w_bit_nxt   = 3'd0;
                    w_shift_nxt = i_data;
                end else begin
                    w_state_nxt = TX_IDLE;
                end
            end
            TX_START: begin
                if (w_clk_last) begin
                    w_state_nxt = TX_DATA;
                    w_clk_nxt   = CNT_ZERO;
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (w_clk_last) begin
                    w_clk_nxt   = CNT_ZERO;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = TX_STOP;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (w_clk_last) begin
                    w_state_nxt = TX_IDLE;
                    w_clk_nxt   = CNT_ZERO;
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
                w_clk_nxt   = CNT_ZERO;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    // Output values as they will be in the state being entered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            TX_IDLE:  w_tx_nxt = 1'b1;
            TX_START: w_tx_nxt = 1'b0;
            TX_DATA:  w_tx_nxt = w_shift_nxt[0];
            TX_STOP:  w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != TX_IDLE);
        w_done_nxt = (w_state_nxt == TX_STOP) && (w_clk_nxt == CNT_LAST);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_clk_cnt <= CNT_ZERO;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/motion_cmd_tx.sv
// Packs the motion requests into a command byte and sends it over UART 8N1 on change.
// Optional periodic resend of an unchanged command: define MOTION_CMD_REFRESH_EN.
module motion_cmd_tx
    import car_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 10417,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       move_forward_signal,
    input  logic       move_backward_signal,
    input  logic       turn_left_signal,
    input  logic       turn_right_signal,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] last_cmd
);

    logic [7:0] r_last_cmd;
    logic [7:0] w_cmd;
    logic       w_core_busy;
    logic       w_refresh;
    logic       w_launch;

    assign w_cmd = sanitise_cmd(enable, move_forward_signal, move_backward_signal,
                                turn_left_signal, turn_right_signal);

    // Mid-frame changes wait here; only the value present on return to idle is sent.
    assign w_launch = !w_core_busy && ((w_cmd != r_last_cmd) || w_refresh);

`ifdef MOTION_CMD_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] IDLE_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [RW-1:0] IDLE_ZERO = RW'(0);
    localparam logic [RW-1:0] IDLE_ONE  = RW'(1);

    logic [RW-1:0] r_idle_cnt;

    assign w_refresh = (r_idle_cnt == IDLE_LAST);

    // Idle-time counter: counts unchanged idle cycles, cleared by every launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= IDLE_ZERO;
        end else if (w_launch) begin
            r_idle_cnt <= IDLE_ZERO;
        end else if (!w_core_busy) begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end
`else
    // Never true for a valid configuration; no resend without the refresh build.
    assign w_refresh = (REFRESH_CYCLES < 0);
`endif

    // Last launched command, loaded on the same edge the frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_cmd <= CMD_STOP;
        end else if (w_launch) begin
            r_last_cmd <= w_cmd;
        end else begin
            r_last_cmd <= r_last_cmd;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst),
        .i_start (w_launch),
        .i_data  (w_cmd),
        .o_tx    (tx),
        .o_busy  (w_core_busy),
        .o_done  (frame_done)
    );

    assign busy     = w_core_busy;
    assign last_cmd = r_last_cmd;

endmodule

// File: tb/tb_motion_cmd_tx.sv
// Self-checking bench for motion_cmd_tx with a frame-level reference model.
module tb_motion_cmd_tx;

    localparam int CPB  = 4;
    localparam int REF  = 100;
    localparam int FLEN = 10 * CPB;
`ifdef MOTION_CMD_REFRESH_EN
    localparam bit REFRESH_ON = 1'b1;
`else
    localparam bit REFRESH_ON = 1'b0;
`endif

    logic       clk, rst, enable, fwd, bwd, left, right;
    logic       tx, busy, frame_done;
    logic [7:0] last_cmd;

    motion_cmd_tx #(.CLKS_PER_BIT(CPB), .REFRESH_CYCLES(REF)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .move_forward_signal(fwd), .move_backward_signal(bwd),
        .turn_left_signal(left), .turn_right_signal(right),
        .tx(tx), .busy(busy), .frame_done(frame_done), .last_cmd(last_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int launch; logic [7:0] b; } exp_t;
    typedef struct { int launch; logic [FLEN-1:0] wave; int done; int ndone; int blen; logic [7:0] lc; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    // Expected line waveform of one frame: start low, 8 data bits LSB first, stop high.
    function automatic logic [FLEN-1:0] wave_of(input logic [7:0] b);
        logic [FLEN-1:0] w;
        for (int k = 0; k < FLEN; k++) begin
            if (k < CPB) w[k] = 1'b0;
            else if (k < 9 * CPB) w[k] = b[(k - CPB) / CPB];
            else w[k] = 1'b1;
        end
        return w;
    endfunction

    // Reference model: command value from the request rules, launches on change when idle.
    int m_cmd;
    assign m_cmd = enable ? (((fwd && !bwd) ? 1 : 0) + ((bwd && !fwd) ? 2 : 0) +
                             ((left && !right) ? 4 : 0) + ((right && !left) ? 8 : 0)) : 0;
    int m_end, m_idle_start;
    int m_last;
    initial begin
        m_end = -1; m_idle_start = 0; m_last = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_last = 0; m_end = -1; m_idle_start = cyc + 1;
            end else if (cyc > m_end) begin
                if ((m_cmd != m_last) || (REFRESH_ON && (cyc - m_idle_start == REF - 1))) begin
                    exp_q.push_back('{launch: cyc, b: 8'(m_cmd)});
                    m_last = m_cmd;
                    m_end = cyc + FLEN;
                    m_idle_start = cyc + FLEN + 1;
                end
            end
        end
    end

    // Monitor: records every observed frame (busy interval) with its line waveform.
    logic in_frame;
    int   idx;
    int   stray;
    obs_t cur;
    initial begin
        in_frame = 1'b0; idx = 0; stray = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (frame_done) stray++;
                if (busy) begin
                    in_frame = 1'b1; idx = 0;
                    cur.launch = cyc - 1; cur.wave = '0; cur.done = -1;
                    cur.ndone = 0; cur.blen = 0; cur.lc = last_cmd;
                end
            end
            if (rst && in_frame) begin
                if (busy && idx < 2 * FLEN) begin
                    if (idx < FLEN) cur.wave[idx] = tx;
                    if (frame_done) begin cur.done = cyc; cur.ndone++; end
                    cur.blen++; idx++;
                end else begin
                    obs_q.push_back(cur);
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; fwd = 1'b0; bwd = 1'b0; left = 1'b0; right = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete(); obs_q.delete(); stray = 0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; fwd = 1'b1; bwd = 1'b1; left = 1'b1; right = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_cmp++; if (last_cmd !== 8'h00) begin n_err++; $display("FAIL reset_last_cmd: got %h want 00", last_cmd); end
        exp_q.delete(); obs_q.delete(); stray = 0;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_no_frame: got %0d frames busy=%b want 0", obs_q.size(), busy); end
        fwd = 1'b1; bwd = 1'b0; left = 1'b0; right = 1'b0;
        for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_mid_launch: got busy=%b want 1", busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL reset_mid_start_low: got %b want 0", tx); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || last_cmd !== 8'h00) begin
            n_err++; $display("FAIL reset_async: got tx=%b busy=%b last=%h want 1 0 00", tx, busy, last_cmd);
        end
    endtask

    task automatic test_forward();
        int t;
        apply_reset();
        @(negedge clk);
        t = cyc; fwd = 1'b1;
        repeat (FLEN + 15) @(negedge clk);
        #1;
        n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL fwd_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0].launch != t) begin n_err++; $display("FAIL fwd_latency: got %0d want %0d", obs_q[0].launch, t); end
            n_cmp++; if (obs_q[0].wave !== wave_of(8'h01)) begin n_err++; $display("FAIL fwd_wave: got %h want %h", obs_q[0].wave, wave_of(8'h01)); end
            n_cmp++; if (obs_q[0].done != t + FLEN || obs_q[0].ndone != 1) begin n_err++; $display("FAIL fwd_done: got %0d x%0d want %0d x1", obs_q[0].done, obs_q[0].ndone, t + FLEN); end
            n_cmp++; if (obs_q[0].blen != FLEN) begin n_err++; $display("FAIL fwd_busy_len: got %0d want %0d", obs_q[0].blen, FLEN); end
        end
        n_cmp++; if (last_cmd !== 8'h01) begin n_err++; $display("FAIL fwd_last_cmd: got %h want 01", last_cmd); end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL fwd_stray_done: got %0d want 0", stray); end
    endtask

    task automatic test_conflict();
        int t, nbusy;
        apply_reset();
        @(negedge clk);
        fwd = 1'b1; bwd = 1'b1;
        nbusy = 0;
        repeat (30) begin @(negedge clk); if (busy) nbusy++; end
        n_cmp++; if (nbusy != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL conflict_fb: got busy_cycles=%0d frames=%0d want 0 0", nbusy, obs_q.size()); end
        t = cyc; bwd = 1'b0; left = 1'b1; right = 1'b1;
        repeat (FLEN + 10) @(negedge clk);
        n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL conflict_lr_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0].wave !== wave_of(8'h01) || obs_q[0].launch != t) begin
                n_err++; $display("FAIL conflict_lr_frame: got %h @%0d want %h @%0d", obs_q[0].wave, obs_q[0].launch, wave_of(8'h01), t);
            end
        end
    endtask

    task automatic test_coalesce();
        apply_reset();
        @(negedge clk);
        fwd = 1'b1;
        repeat (6) @(negedge clk);
        fwd = 1'b0; left = 1'b1;
        repeat (8) @(negedge clk);
        left = 1'b0; right = 1'b1;
        repeat (8) @(negedge clk);
        right = 1'b0; left = 1'b1;
        repeat (FLEN + 40) @(negedge clk);
        n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL coalesce_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            n_cmp++; if (obs_q[0].wave !== wave_of(8'h01)) begin n_err++; $display("FAIL coalesce_first: got %h want %h", obs_q[0].wave, wave_of(8'h01)); end
            n_cmp++; if (obs_q[1].wave !== wave_of(8'h04)) begin n_err++; $display("FAIL coalesce_second: got %h want %h", obs_q[1].wave, wave_of(8'h04)); end
            n_cmp++; if (obs_q[1].launch != obs_q[0].done + 1) begin n_err++; $display("FAIL coalesce_b2b: got %0d want %0d", obs_q[1].launch, obs_q[0].done + 1); end
        end
        n_cmp++; if (last_cmd !== 8'h04) begin n_err++; $display("FAIL coalesce_last_cmd: got %h want 04", last_cmd); end
    endtask

    task automatic test_disable();
        int t;
        apply_reset();
        @(negedge clk);
        t = cyc; right = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (2 * FLEN + 40) @(negedge clk);
        n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL disable_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            n_cmp++; if (obs_q[0].wave !== wave_of(8'h08) || obs_q[0].done != t + FLEN) begin
                n_err++; $display("FAIL disable_first: got %h done %0d want %h done %0d", obs_q[0].wave, obs_q[0].done, wave_of(8'h08), t + FLEN);
            end
            n_cmp++; if (obs_q[1].wave !== wave_of(8'h00) || obs_q[1].launch != obs_q[0].done + 1) begin
                n_err++; $display("FAIL disable_stop: got %h @%0d want %h @%0d", obs_q[1].wave, obs_q[1].launch, wave_of(8'h00), obs_q[0].done + 1);
            end
        end
        n_cmp++; if (last_cmd !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL disable_idle: got last=%h busy=%b want 00 0", last_cmd, busy); end
    endtask

    task automatic test_refresh();
        apply_reset();
        @(negedge clk);
        right = 1'b1;
        repeat (3 * (FLEN + REF) + 20) @(negedge clk);
`ifdef MOTION_CMD_REFRESH_EN
        n_cmp++; if (obs_q.size() < 3) begin n_err++; $display("FAIL refresh_count: got %0d want >=3", obs_q.size()); end
        for (int i = 1; i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i].launch != obs_q[i-1].done + REF || obs_q[i].wave !== wave_of(8'h08)) begin
                n_err++; $display("FAIL refresh_frame%0d: got @%0d %h want @%0d %h", i, obs_q[i].launch, obs_q[i].wave, obs_q[i-1].done + REF, wave_of(8'h08));
            end
        end
`else
        n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL norefresh_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0].wave !== wave_of(8'h08)) begin n_err++; $display("FAIL norefresh_wave: got %h want %h", obs_q[0].wave, wave_of(8'h08)); end
        end
`endif
    endtask

    task automatic test_random();
        bit ok;
        int n;
        apply_reset();
        for (int s = 0; s < 40; s++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 7) != 0);
            fwd = $urandom_range(0, 1); bwd = $urandom_range(0, 1);
            left = $urandom_range(0, 1); right = $urandom_range(0, 1);
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (!busy && cyc > m_end) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL random_drain: got busy=%b want idle within 400 cycles", busy); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (obs_q[i].launch != exp_q[i].launch || obs_q[i].wave !== wave_of(exp_q[i].b) ||
                obs_q[i].done != exp_q[i].launch + FLEN || obs_q[i].ndone != 1 ||
                obs_q[i].blen != FLEN || obs_q[i].lc !== exp_q[i].b) begin
                n_err++;
                $display("FAIL random_frame%0d: got @%0d %h done %0d lc %h want @%0d %h done %0d lc %h",
                         i, obs_q[i].launch, obs_q[i].wave, obs_q[i].done, obs_q[i].lc,
                         exp_q[i].launch, wave_of(exp_q[i].b), exp_q[i].launch + FLEN, exp_q[i].b);
            end
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL random_stray_done: got %0d want 0", stray); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_conflict();
        test_coalesce();
        test_disable();
        test_refresh();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
